// File: rtl/key_scan_ctl_pkg.sv
// key_scan_ctl_pkg: shared keypad constants, column drive patterns and debounce FSM states.
package key_scan_ctl_pkg;
    localparam int BCD_BIT_WIDTH = 4;
    localparam int KEY_COL_NUM = 4;
    localparam int KEY_ROW_NUM = 4;
    localparam logic [3:0] KEY_COL0 = 4'b0111;
    localparam logic [3:0] KEY_COL1 = 4'b1011;
    localparam logic [3:0] KEY_COL2 = 4'b1101;
    localparam logic [3:0] KEY_COL3 = 4'b1110;
    typedef enum logic [1:0] {IDLE = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2} key_state_e;
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return idx == 2'd0 ? KEY_COL0 : idx == 2'd1 ? KEY_COL1 : idx == 2'd2 ? KEY_COL2 : KEY_COL3;
    endfunction
endpackage

// File: rtl/key_col_scan.sv
// key_col_scan: column rotation, row synchronizer and per-frame first-hit capture.
module key_col_scan
    import key_scan_ctl_pkg::*;
#(
    parameter int SCAN_DIV = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       frame_done,
    output logic       frame_hit,
    output logic [3:0] frame_code
);
    localparam int DW = $clog2(SCAN_DIV);
    logic [DW-1:0] dwell;
    logic [1:0] col_idx, row_idx;
    logic [3:0] sync1, sync2, cap_code;
    logic cap_hit, col_hit, sample;
    always_comb begin
        sample = dwell == DW'(SCAN_DIV - 1);
        col_hit = ~&sync2;
        row_idx = !sync2[0] ? 2'd0 : !sync2[1] ? 2'd1 : !sync2[2] ? 2'd2 : 2'd3;
        key_col = col_drive(col_idx);
        frame_done = sample && col_idx == 2'd3;
        frame_hit = cap_hit || col_hit;
        frame_code = cap_hit ? cap_code : {row_idx, col_idx};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell <= '0;
            col_idx <= 2'd0;
            sync1 <= 4'hF;
            sync2 <= 4'hF;
            cap_hit <= 1'b0;
            cap_code <= 4'h0;
        end else begin
            sync1 <= key_row;
            sync2 <= sync1;
            dwell <= sample ? '0 : dwell + DW'(1);
            if (sample) begin
                col_idx <= col_idx + 2'd1;
                // scan order gives col 0 first, lowest row first: keep only the first hit
                if (frame_done) begin
                    cap_hit <= 1'b0;
                    cap_code <= 4'h0;
                end else if (!cap_hit && col_hit) begin
                    cap_hit <= 1'b1;
                    cap_code <= {row_idx, col_idx};
                end
            end
        end
    end
endmodule

// File: rtl/key_scan_ctl.sv
// key_scan_ctl: 4x4 keypad scanner with frame-level press/release debounce.
module key_scan_ctl
    import key_scan_ctl_pkg::*;
#(
    parameter int SCAN_DIV = 2500,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [3:0]               key_col,
    input  logic [3:0]               key_row,
    output logic [BCD_BIT_WIDTH-1:0] key_code,
    output logic                     key_valid,
    output logic                     key_pressed
);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DF = CW'(DEBOUNCE_FRAMES);
    logic frame_done, frame_hit, accept;
    logic [3:0] frame_code, cand, n_cand, n_code;
    logic [CW-1:0] cnt, n_cnt, rel_cnt, n_rel;
    logic n_valid, n_pressed;
    key_state_e state, n_state;
    key_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk(clk),
        .rst_n(rst_n),
        .key_row(key_row),
        .key_col(key_col),
        .frame_done(frame_done),
        .frame_hit(frame_hit),
        .frame_code(frame_code)
    );
    always_comb begin
        n_state = state;
        n_cand = cand;
        n_cnt = cnt;
        n_rel = rel_cnt;
        n_code = key_code;
        n_valid = 1'b0;
        n_pressed = key_pressed;
        accept = 1'b0;
        if (frame_done) begin
            case (state)
                IDLE: if (frame_hit) begin
                    if (DEBOUNCE_FRAMES == 1) accept = 1'b1;
                    else begin
                        n_state = DEBOUNCE;
                        n_cand = frame_code;
                        n_cnt = CW'(1);
                    end
                end
                DEBOUNCE: if (!frame_hit) n_state = IDLE;
                    else if (frame_code != cand) begin
                        n_cand = frame_code;
                        n_cnt = CW'(1);
                    end else if (cnt + CW'(1) == DF) accept = 1'b1;
                    else n_cnt = cnt + CW'(1);
                HELD: if (frame_hit) n_rel = '0;
                    else if (rel_cnt + CW'(1) == DF) begin
                        n_state = IDLE;
                        n_pressed = 1'b0;
                    end else n_rel = rel_cnt + CW'(1);
                default: n_state = IDLE;
            endcase
        end
        if (accept) begin
            n_state = HELD;
            n_code = frame_code;
            n_valid = 1'b1;
            n_pressed = 1'b1;
            n_rel = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cand <= 4'h0;
            cnt <= '0;
            rel_cnt <= '0;
            key_code <= '0;
            key_valid <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            state <= n_state;
            cand <= n_cand;
            cnt <= n_cnt;
            rel_cnt <= n_rel;
            key_code <= n_code;
            key_valid <= n_valid;
            key_pressed <= n_pressed;
        end
    end
endmodule

// File: tb/tb_key_scan_ctl.sv
// tb_key_scan_ctl: keypad matrix model driving key_scan_ctl, with a queue scoreboard on key_valid.
module tb_key_scan_ctl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] key_col, key_row, key_code, mon_exp;
    logic key_valid, key_pressed;
    logic [15:0] keys = 16'h0;
    logic [3:0] pats [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [3:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_scan_ctl #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_col(key_col),
        .key_row(key_row),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_pressed(key_pressed)
    );

    // key k = row*4 + col shorts row k/4 low while its column (bit 3-col) is driven low
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !key_col[3-c]) key_row[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            int t = 0;
            do begin @(negedge clk); t++; end while (key_col != 4'b1110 && t < 40);
            do begin @(negedge clk); t++; end while (key_col != 4'b0111 && t < 80);
            if (t >= 80) chk("frame_timeout", key_col, 4'b0111);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: key_code=%h, no pulse expected at %0t", key_code, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== mon_exp || key_pressed !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_code: got code %h pressed %b, expected code %h pressed 1 at %0t",
                             key_code, key_pressed, mon_exp, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_col", key_col, 4'b0111);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", {3'b0, key_valid}, 4'h0);
        chk("rst_pressed", {3'b0, key_pressed}, 4'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("scan_col", key_col, pats[(i/4)%4]);
            @(negedge clk);
        end
        frames(1);
        chk("idle_pressed", {3'b0, key_pressed}, 4'h0);
        chk("idle_code", key_code, 4'h0);

        keys = 16'h1 << 10;
        exp_q.push_back(4'hA);
        frames(2);
        chk("a_early_valid", {3'b0, key_valid}, 4'h0);
        chk("a_early_pressed", {3'b0, key_pressed}, 4'h0);
        frames(1);
        chk("a_valid", {3'b0, key_valid}, 4'h1);
        chk("a_code", key_code, 4'hA);
        frames(1);
        chk("a_held", {3'b0, key_pressed}, 4'h1);
        keys = 16'h0;
        frames(2);
        chk("a_rel_partial", {3'b0, key_pressed}, 4'h1);
        frames(1);
        chk("a_released", {3'b0, key_pressed}, 4'h0);
        chk("a_code_kept", key_code, 4'hA);

        keys = 16'h1 << 5;
        exp_q.push_back(4'h5);
        frames(1);
        keys = 16'h0;
        frames(1);
        keys = 16'h1 << 5;
        frames(2);
        chk("b_early_valid", {3'b0, key_valid}, 4'h0);
        chk("b_early_pressed", {3'b0, key_pressed}, 4'h0);
        frames(1);
        chk("b_valid", {3'b0, key_valid}, 4'h1);
        chk("b_code", key_code, 4'h5);
        keys = 16'h0;
        frames(3);
        chk("b_released", {3'b0, key_pressed}, 4'h0);

        keys = 16'h1 << 9;
        exp_q.push_back(4'h9);
        frames(3);
        chk("m_valid", {3'b0, key_valid}, 4'h1);
        keys = (16'h1 << 9) | (16'h1 << 3);
        frames(2);
        chk("m_both_code", key_code, 4'h9);
        keys = 16'h1 << 3;
        frames(4);
        chk("m_other_pressed", {3'b0, key_pressed}, 4'h1);
        chk("m_other_code", key_code, 4'h9);
        keys = 16'h0;
        frames(2);
        chk("m_rel_partial", {3'b0, key_pressed}, 4'h1);
        frames(1);
        chk("m_released", {3'b0, key_pressed}, 4'h0);
        keys = 16'h1 << 3;
        exp_q.push_back(4'h3);
        frames(3);
        chk("m3_valid", {3'b0, key_valid}, 4'h1);
        chk("m3_code", key_code, 4'h3);
        keys = 16'h0;
        frames(3);
        chk("m3_released", {3'b0, key_pressed}, 4'h0);

        keys = 16'h1 << 6;
        frames(1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_col", key_col, 4'b0111);
        chk("mr_code", key_code, 4'h0);
        chk("mr_valid", {3'b0, key_valid}, 4'h0);
        chk("mr_pressed", {3'b0, key_pressed}, 4'h0);
        rst_n = 1'b1;
        exp_q.push_back(4'h6);
        frames(2);
        chk("mr_early_valid", {3'b0, key_valid}, 4'h0);
        chk("mr_early_pressed", {3'b0, key_pressed}, 4'h0);
        frames(1);
        chk("mr_valid_after", {3'b0, key_valid}, 4'h1);
        chk("mr_code_after", key_code, 4'h6);

        keys = 16'h0;
        frames(2);
        keys = 16'h1 << 6;
        frames(2);
        chk("rd_still_pressed", {3'b0, key_pressed}, 4'h1);
        keys = 16'h0;
        frames(2);
        chk("rd_rel_partial", {3'b0, key_pressed}, 4'h1);
        frames(1);
        chk("rd_released", {3'b0, key_pressed}, 4'h0);

        repeat (20) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_pulses: %0d expected pulses never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
